// File: rtl/load_store_unit.sv
// load_store_unit
//   Byte/half/word load-store engine between an RV32I core and a word-wide
//   data memory with an asynchronous read port. Sub-word stores are
//   done as read-modify-write (read word, merge lane, write word).
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   req_valid         core presents an access (accepted only while busy=0)
//   req_we            1 = store, 0 = load
//   funct3            RV32I width code (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   addr, wdata       byte address and store data (sub-word data in low bits)
//   busy              high whenever the FSM is not IDLE
//   done, err         one-cycle completion pulse; err marks a rejected access
//   rdata             extended load result, held until the next load completes
//   mem_we, mem_a     data-memory write enable and word-aligned address
//   mem_wd, mem_rd    data-memory write word and asynchronous read word
//   dbg_state         current FSM state (IDLE=0, LOAD=1, RMW=2, STORE=3)
//
// Configuration
//   LSU_MISALIGN_TRAP_EN  defined: misaligned half/word accesses are rejected.
//                         undefined: misaligned accesses use the naturally
//                         aligned lane and only illegal funct3 is rejected.
//
// Handshake: a request transfers on a rising edge where req_valid=1 and
// busy=0 (busy acts as the inverse of ready). A request presented while
// busy=1 is dropped, not held; the core must re-present it. The done cycle
// is IDLE, so a new request can transfer on it (back-to-back operation).

module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RMW   = 2'd2,
        STORE = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  funct3_q;
    logic        we_q;
    logic [31:0] merge_q;

    logic        reject;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_val;
    logic [31:0] merge_word;

    // Accept-time classification of the incoming request.
    always_comb begin
        reject = 1'b0;
        if (req_we)
            reject = funct3[2] | (funct3[1:0] == 2'b11);
        else
            reject = (funct3 == 3'b011) | (funct3[2:1] == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((funct3[1:0] == 2'b01) && addr[0])
            reject = 1'b1;
        if ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00))
            reject = 1'b1;
`endif
    end

    // Lane extraction and merge. Half lanes only look at addr_q[1] and
    // words ignore addr_q[1:0], which gives natural alignment when
    // misaligned accesses are allowed through.
    always_comb begin
        byte_lane = mem_rd[{addr_q[1:0], 3'b000} +: 8];
        half_lane = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
        case (funct3_q)
            3'b000:  load_val = {{24{byte_lane[7]}}, byte_lane};
            3'b001:  load_val = {{16{half_lane[15]}}, half_lane};
            3'b100:  load_val = {24'd0, byte_lane};
            3'b101:  load_val = {16'd0, half_lane};
            default: load_val = mem_rd;
        endcase
        merge_word = mem_rd;
        if (funct3_q[0])
            merge_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        else
            merge_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            funct3_q <= 3'd0;
            we_q     <= 1'b0;
            merge_q  <= 32'd0;
            rdata    <= 32'd0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q   <= addr;
                        wdata_q  <= wdata;
                        funct3_q <= funct3;
                        we_q     <= req_we;
                        if (reject) begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else if (!req_we) begin
                            state <= LOAD;
                        end else if (funct3[1:0] == 2'b10) begin
                            state <= STORE;
                        end else begin
                            state <= RMW;
                        end
                    end
                end
                LOAD: begin
                    rdata <= load_val;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                RMW: begin
                    merge_q <= merge_word;
                    state   <= STORE;
                end
                STORE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign mem_we    = (state == STORE);
    assign mem_a     = {addr_q[31:2], 2'b00};
    // we_q is folded in so a full-word store always writes the captured data.
    assign mem_wd    = (we_q && (funct3_q[1:0] == 2'b10)) ? wdata_q : merge_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_we    (mem_we),
        .mem_a     (mem_a),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd),
        .dbg_state (dbg_state)
    );

    // Data memory (16 words) driven by the DUT, plus a bench preload port.
    logic [31:0] mem [16];
    logic        pre_en = 1'b0;
    logic [3:0]  pre_idx = 4'd0;
    logic [31:0] pre_val = 32'd0;
    assign mem_rd = mem[mem_a[5:2]];
    always @(posedge clk) begin
        if (mem_we)
            mem[mem_a[5:2]] <= mem_wd;
        else if (pre_en)
            mem[pre_idx] <= pre_val;
    end

    // Reference model state.
    logic [31:0] ref_mem [16];
    logic [31:0] exp_rdata = 32'd0;
    logic [31:0] exp_q[$];

    int checks = 0;
    int errors = 0;

    // Results of the latest driven access.
    int          last_lat, last_wcnt, last_wlat;
    logic        last_err;
    logic [31:0] last_rdata, last_wa, last_wd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        pre_idx = 4'(idx);
        pre_val = val;
        pre_en  = 1'b1;
        @(posedge clk);
        #1 pre_en = 1'b0;
        ref_mem[idx] = val;
    endtask

    // Issue one access, compare against the model. Returns at the negedge
    // of the done cycle so the next call transfers back-to-back.
    task automatic do_access(input logic we, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd);
        int          idx, sz, off, e_lat, e_wr;
        logic        legal, mis, rej;
        logic [31:0] w, val, mask, nw;
        bit          got;
        idx = int'(a[5:2]);
        w   = ref_mem[idx];
        sz  = int'(f3[1:0]);
        nw  = w;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        mis   = (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00);
`ifdef LSU_MISALIGN_TRAP_EN
        rej = !legal || mis;
`else
        rej = !legal;
`endif
        off = (sz == 0) ? int'(a[1:0]) : (sz == 1) ? (a[1] ? 2 : 0) : 0;
        e_wr = 0;
        if (rej) begin
            e_lat = 1;
        end else if (!we) begin
            e_lat = 2;
            val = w >> (8 * off);
            if (sz == 0) begin
                val = val & 32'hFF;
                if (!f3[2] && val[7]) val = val | 32'hFFFFFF00;
            end else if (sz == 1) begin
                val = val & 32'hFFFF;
                if (!f3[2] && val[15]) val = val | 32'hFFFF0000;
            end
            exp_rdata = val;
        end else begin
            e_lat = (sz == 2) ? 2 : 3;
            e_wr  = 1;
            if (sz == 2) begin
                nw = wd;
            end else begin
                mask = ((sz == 0) ? 32'hFF : 32'hFFFF) << (8 * off);
                nw = (w & ~mask) | ((wd << (8 * off)) & mask);
            end
            ref_mem[idx] = nw;
        end
        exp_q.push_back(exp_rdata);

        req_we = we; funct3 = f3; addr = a; wdata = wd; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        got = 0; last_lat = 0; last_wcnt = 0; last_wlat = 0;
        last_err = 1'b0; last_rdata = 32'd0; last_wa = 32'd0; last_wd = 32'd0;
        for (int c = 1; c <= 6 && !got; c++) begin
            @(negedge clk);
            if (mem_we) begin
                last_wcnt++; last_wlat = c; last_wa = mem_a; last_wd = mem_wd;
            end
            if (done) begin
                got = 1; last_lat = c; last_err = err; last_rdata = rdata;
            end
        end
        check("done_seen", 32'(got), 32'd1);
        check("latency", 32'(last_lat), 32'(e_lat));
        check("err", 32'(last_err), 32'(rej));
        check("rdata", last_rdata, exp_q.pop_front());
        check("write_count", 32'(last_wcnt), 32'(e_wr));
        if (e_wr == 1) begin
            check("write_cycle", 32'(last_wlat), 32'(e_lat - 1));
            check("mem_a", last_wa, {a[31:2], 2'b00});
            check("mem_wd", last_wd, nw);
        end
    endtask

    initial begin
        int dones, wes, first_done, second_done;
        logic [31:0] rd_at_second;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
        for (int i = 0; i < 16; i++) preload(i, $urandom);

        // Reset state.
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_wd", mem_wd, 32'd0);
        rst_n = 1'b1;

        // SW 0x10 right after reset release.
        do_access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        check("sw_wcycle", 32'(last_wlat), 32'd1);
        check("sw_mem_a", last_wa, 32'h10);
        check("sw_mem_wd", last_wd, 32'hDEADBEEF);
        check("sw_done_cycle", 32'(last_lat), 32'd2);

        // Load extension on 0x80FF7F01.
        preload(4, 32'h80FF7F01);
        do_access(1'b0, 3'b000, 32'h13, 32'd0);
        check("lb_13", last_rdata, 32'hFFFFFF80);
        do_access(1'b0, 3'b100, 32'h13, 32'd0);
        check("lbu_13", last_rdata, 32'h00000080);
        do_access(1'b0, 3'b001, 32'h12, 32'd0);
        check("lh_12", last_rdata, 32'hFFFF80FF);
        do_access(1'b0, 3'b101, 32'h12, 32'd0);
        check("lhu_12", last_rdata, 32'h000080FF);

        // SB read-modify-write.
        preload(8, 32'h11223344);
        do_access(1'b1, 3'b000, 32'h21, 32'h000000AA);
        check("sb_wcycle", 32'(last_wlat), 32'd2);
        check("sb_mem_a", last_wa, 32'h20);
        check("sb_mem_wd", last_wd, 32'h1122AA44);
        check("sb_done_cycle", 32'(last_lat), 32'd3);

        // Misaligned LW at 0x6.
        preload(1, 32'hCAFEF00D);
        do_access(1'b0, 3'b010, 32'h6, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("lw6_err", 32'(last_err), 32'd1);
        check("lw6_done_cycle", 32'(last_lat), 32'd1);
        check("lw6_no_write", 32'(last_wcnt), 32'd0);
`else
        check("lw6_err", 32'(last_err), 32'd0);
        check("lw6_rdata", last_rdata, 32'hCAFEF00D);
`endif

        // SW followed by LW presented during busy and held to the done cycle.
        preload(3, 32'h0BADF00D);
        req_we = 1'b1; funct3 = 3'b010; addr = 32'h14; wdata = 32'h12345678;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_we = 1'b0; addr = 32'hC; wdata = 32'd0;
        dones = 0; wes = 0; first_done = 0; second_done = 0; rd_at_second = 32'd0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (mem_we) wes++;
            if (done) begin
                dones++;
                if (dones == 1) first_done = c;
                else begin second_done = c; rd_at_second = rdata; end
            end
            if (c == 2) begin
                @(posedge clk);
                #1 req_valid = 1'b0;
            end
        end
        ref_mem[5] = 32'h12345678;
        exp_rdata = 32'h0BADF00D;
        check("b2b_dones", 32'(dones), 32'd2);
        check("b2b_first", 32'(first_done), 32'd2);
        check("b2b_second", 32'(second_done), 32'd4);
        check("b2b_rdata", rd_at_second, 32'h0BADF00D);
        check("b2b_writes", 32'(wes), 32'd1);

        // Store presented while a load is busy must be dropped.
        req_we = 1'b0; funct3 = 3'b010; addr = 32'h8; req_valid = 1'b1;
        @(posedge clk);
        #1 req_we = 1'b1; wdata = 32'hFFFFFFFF;
        dones = 0; wes = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) check("drop_busy", 32'(busy), 32'd1);
            if (mem_we) wes++;
            if (done) begin
                dones++;
                check("drop_rdata", rdata, ref_mem[2]);
            end
            if (c == 1) begin
                @(posedge clk);
                #1 req_valid = 1'b0;
            end
        end
        exp_rdata = ref_mem[2];
        check("drop_dones", 32'(dones), 32'd1);
        check("drop_writes", 32'(wes), 32'd0);

        // Reset pulsed during RMW of an SH.
        preload(6, 32'h55667788);
        req_we = 1'b1; funct3 = 3'b001; addr = 32'h1A; wdata = 32'h9999;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rmw_busy", 32'(busy), 32'd1);
        check("rmw_state_live", 32'(dbg_state != 2'd0), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_mem_we", 32'(mem_we), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_rdata", rdata, 32'd0);
        check("abort_mem_wd", mem_wd, 32'd0);
        exp_rdata = 32'd0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0; wes = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (mem_we) wes++;
            if (done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        check("abort_no_write", 32'(wes), 32'd0);

        // Randomized traffic, back-to-back.
        for (int n = 0; n < 80; n++) begin
            do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      32'($urandom_range(0, 63)), $urandom);
        end

        // Final memory image.
        @(negedge clk);
        for (int i = 0; i < 16; i++) check("mem_image", mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req_valid  input  1  core presents an access this cycle.
REQ-005 req_we  input  1  1 = store, 0 = load.
REQ-006 funct3  input  3  RV32I width code: load 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW.
REQ-007 addr  input  32  byte address.
REQ-008 wdata  input  32  store data; sub-word data is taken from the low bits.
REQ-009 busy  output  1  high whenever state is not IDLE; requests are not accepted.
REQ-010 done  output  1  one-cycle pulse when an access completes.
REQ-011 err  output  1  valid with done; the access was rejected and memory was untouched.
REQ-012 rdata  output  32  extended load result; valid when done=1 and the access was a load.
REQ-013 mem_we  output  1  data-memory write enable.
REQ-014 mem_a  output  32  data-memory address, always word-aligned ({addr_q[31:2],2'b00}).
REQ-015 mem_wd  output  32  data-memory write word.
REQ-016 mem_rd  input  32  data-memory asynchronous read word.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, RMW and STORE.
REQ-018 In IDLE with req_valid=1, the block SHALL capture addr, wdata, funct3 and req_we into internal registers. Requests that arrive while busy=1 SHALL be dropped.
REQ-019 Next-state after accept SHALL be:
- rejected access: IDLE, with done=1 and err=1 in the next cycle;
- any load: LOAD;
- SW: STORE;
- SB or SH: RMW.
REQ-020 An access SHALL be rejected for either of these causes:
- illegal funct3 (load 011/110/111; store 011 and above);
- misaligned address (halfword with addr[0]=1; word with addr[1:0] not 00), subject to REQ-031.
REQ-021 LOAD, one cycle:
- mem_we=0;
- rdata SHALL be registered from mem_rd, using byte lane addr_q[1:0] and half lane addr_q[1];
- LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend, little-endian;
- next state IDLE, with done=1 in the following cycle.
REQ-022 RMW, one cycle: mem_we=0. The block SHALL register a merge word equal to mem_rd with the addressed byte or half lane replaced by wdata_q[7:0] or wdata_q[15:0]. Next state is STORE.
REQ-023 STORE, one cycle:
- mem_we=1;
- mem_wd = wdata_q for SW, or the merge word for SB/SH;
- next state IDLE, with done=1 in the following cycle.
REQ-024 mem_we SHALL be high only in STORE.
REQ-025 Latency from the accept cycle N: load done at N+2; SW done at N+2; SB/SH done at N+3; rejected done at N+1.
REQ-026 rdata SHALL hold its value until the next load completes. Stores and rejections SHALL leave rdata unchanged.
REQ-027 req_valid=1 in the same cycle that done=1 (state IDLE) SHALL be accepted, giving back-to-back operation.

Reset
REQ-028 Asserting rst_n=0 SHALL immediately force:
- state = IDLE;
- busy, done, err and mem_we = 0;
- rdata, mem_a, mem_wd and all capture registers = 0.
REQ-029 Reset asserted mid-operation (including in RMW or STORE) SHALL abort the access. No memory write SHALL occur, and no done SHALL be issued for it.
REQ-030 After rst_n deasserts, the first rising edge SHALL be able to accept a request.

Configuration
REQ-031 Macro LSU_MISALIGN_TRAP_EN controls misaligned handling.
- Defined: misaligned accesses SHALL be rejected per REQ-020.
- Undefined: misaligned accesses SHALL proceed with the lane index forced to natural alignment (LH/SH use addr[1]; LW/SW ignore addr[1:0]), and err SHALL assert only for illegal funct3.

Verification
REQ-032 Reset, then SW addr=0x10 wdata=0xDEADBEEF -> mem_we=1 with mem_a=0x10 and mem_wd=0xDEADBEEF at N+1; done at N+2.
REQ-033 mem_rd=0x80FF7F01, LB at addr 0x13 -> rdata=0xFFFFFF80; LBU at 0x13 -> 0x00000080; LH at 0x12 -> 0xFFFF80FF; LHU at 0x12 -> 0x000080FF.
REQ-034 mem_rd=0x11223344, SB addr=0x21 wdata=0xAA -> no write at N+1; mem_we=1 with mem_a=0x20 and mem_wd=0x1122AA44 at N+2; done at N+3.
REQ-035 LW addr=0x6 with macro defined -> done=1 and err=1 at N+1 and mem_we never asserts. Without the macro -> reads word 0x4 with err=0.
REQ-036 rst_n pulsed low during RMW of an SH -> mem_we stays 0, busy=0, and no done pulse.
REQ-037 LW accepted on the done cycle of a preceding SW -> both complete, second done two cycles after the first, and a req_valid asserted while busy is ignored.
